// File: rtl/imm_wide_load_seq.sv
// Builds a 64-bit constant by chaining move-wide steps (MOVZ then MOVKs) through the shared sign extender.
// Optional IMM_WIDE_LOAD_SEQ_CHECK_EN adds a Mismatch output comparing the built value with the request.
`timescale 1ns/1ps
module imm_wide_load_seq #(
  parameter bit SKIP_ZERO_HW = 1'b1
) (
  input  logic        Clk,
  input  logic        Resetl,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [63:0] ReqValue,
  input  logic        Flush,
  output logic [25:0] Imm26,
  output logic [2:0]  ExtCtrl,
  output logic        StepValid,
  output logic        StepKeep,
  input  logic [63:0] BusImm,
  output logic [63:0] Result,
  output logic        Done,
`ifdef IMM_WIDE_LOAD_SEQ_CHECK_EN
  output logic        Mismatch,
`endif
  output logic [2:0]  StepCount
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      state;
  logic [63:0] val, acc, acc_n, mask;
  logic [1:0]  cur_hw, nhw, hw0;
  logic [2:0]  cnt;
  logic        is_last;

  // Lowest halfword index at or above ptr that is nonzero; falls back to ptr
  // (so an all-zero value still gets its single MOVZ at hw=0).
  function automatic logic [1:0] pick(input logic [63:0] v, input logic [2:0] ptr);
    pick = ptr[1:0];
    if (SKIP_ZERO_HW)
      for (int i = 3; i >= 0; i--)
        if (i >= int'(ptr) && v[16*i +: 16] != 16'h0) pick = 2'(i);
  endfunction

  function automatic logic last_step(input logic [63:0] v, input logic [1:0] hw);
    last_step = (hw == 2'd3);
    if (SKIP_ZERO_HW) begin
      last_step = 1'b1;
      for (int i = 0; i < 4; i++)
        if (i > int'(hw) && v[16*i +: 16] != 16'h0) last_step = 1'b0;
    end
  endfunction

  assign mask    = 64'hFFFF << {cur_hw, 4'b0};
  assign acc_n   = StepKeep ? ((acc & ~mask) | (BusImm & mask)) : BusImm;
  assign nhw     = pick(val, {1'b0, cur_hw} + 3'd1);
  assign hw0     = pick(ReqValue, 3'd0);
  assign is_last = last_step(val, cur_hw);

  always_ff @(posedge Clk or negedge Resetl) begin
    if (!Resetl) begin
      state     <= IDLE;
      ReqReady  <= 1'b1;
      Imm26     <= '0;
      ExtCtrl   <= '0;
      StepValid <= 1'b0;
      StepKeep  <= 1'b0;
      Result    <= '0;
      Done      <= 1'b0;
      StepCount <= '0;
      val       <= '0;
      acc       <= '0;
      cur_hw    <= '0;
      cnt       <= '0;
`ifdef IMM_WIDE_LOAD_SEQ_CHECK_EN
      Mismatch  <= 1'b0;
`endif
    end else if (Flush && state != IDLE) begin
      state     <= IDLE;
      ReqReady  <= 1'b1;
      Imm26     <= '0;
      ExtCtrl   <= '0;
      StepValid <= 1'b0;
      StepKeep  <= 1'b0;
      Done      <= 1'b0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: if (!Flush && ReqValid) begin
          state     <= ISSUE;
          ReqReady  <= 1'b0;
          val       <= ReqValue;
          acc       <= '0;
          cnt       <= '0;
          cur_hw    <= hw0;
          Imm26     <= {3'b0, hw0, ReqValue[{hw0, 4'b0} +: 16], 5'b0};
          ExtCtrl   <= 3'b100;
          StepValid <= 1'b1;
          StepKeep  <= 1'b0;
`ifdef IMM_WIDE_LOAD_SEQ_CHECK_EN
          Mismatch  <= 1'b0;
`endif
        end
        ISSUE: begin
          acc <= acc_n;
          cnt <= cnt + 3'd1;
          if (is_last) begin
            state     <= DONE;
            Imm26     <= '0;
            ExtCtrl   <= '0;
            StepValid <= 1'b0;
            StepKeep  <= 1'b0;
            Result    <= acc_n;
            Done      <= 1'b1;
            StepCount <= cnt + 3'd1;
`ifdef IMM_WIDE_LOAD_SEQ_CHECK_EN
            Mismatch  <= (acc_n != val);
`endif
          end else begin
            cur_hw   <= nhw;
            Imm26    <= {3'b0, nhw, val[{nhw, 4'b0} +: 16], 5'b0};
            StepKeep <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          ReqReady <= 1'b1;
          Done     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMM_WIDE_LOAD_SEQ_CHECK_EN
  always_ff @(posedge Clk)
    if (Done && Mismatch) $error("imm_wide_load_seq: built %h, requested %h", Result, val);
`endif

endmodule

// File: tb/tb_imm_wide_load_seq.sv
// Scoreboard bench for imm_wide_load_seq: directed constants, expected steps/results queued by stimulus.
`timescale 1ns/1ps
module tb_imm_wide_load_seq;

  logic        Clk = 1'b0, Resetl = 1'b0;
  logic        ReqValid = 1'b0, Flush = 1'b0, ReqReady;
  logic [63:0] ReqValue = '0, BusImm, Result;
  logic [25:0] Imm26;
  logic [2:0]  ExtCtrl, StepCount;
  logic        StepValid, StepKeep, Done;
`ifdef IMM_WIDE_LOAD_SEQ_CHECK_EN
  logic        Mismatch;
`endif

  always #5 Clk = ~Clk;

  imm_wide_load_seq dut (
    .Clk(Clk), .Resetl(Resetl), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqValue(ReqValue), .Flush(Flush), .Imm26(Imm26), .ExtCtrl(ExtCtrl),
    .StepValid(StepValid), .StepKeep(StepKeep), .BusImm(BusImm),
    .Result(Result), .Done(Done),
`ifdef IMM_WIDE_LOAD_SEQ_CHECK_EN
    .Mismatch(Mismatch),
`endif
    .StepCount(StepCount)
  );

  // Extender model: move-wide places imm16 at its halfword, zero elsewhere.
  logic force_zero = 1'b0;
  assign BusImm = (force_zero || !ExtCtrl[2]) ? 64'h0 :
                  ({48'h0, Imm26[20:5]} << (16 * Imm26[22:21]));

  typedef struct {logic [1:0] hw; logic [15:0] imm; logic keep;} step_t;
  typedef struct {logic [63:0] res; logic [2:0] cnt; int lat; logic mm;} done_t;

  step_t  sq[$];
  done_t  dq[$];
  longint acc_t[$];
  step_t  ms;
  done_t  md;
  longint last_done_t = 0;
  int     checks = 0, errors = 0;
  logic   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_step(input logic [1:0] hw, input logic [15:0] imm, input logic keep);
    step_t s;
    s.hw = hw; s.imm = imm; s.keep = keep;
    sq.push_back(s);
  endtask

  task automatic exp_done(input logic [63:0] res, input logic [2:0] cnt, input int lat, input logic mm);
    done_t d;
    d.res = res; d.cnt = cnt; d.lat = lat; d.mm = mm;
    dq.push_back(d);
  endtask

  // Monitor: every live step and every Done is matched against the queues.
  always @(negedge Clk) if (mon_en) begin
    if (StepValid) begin
      if (sq.size() == 0) chk("unexpected_step", 64'(Imm26), 64'hX);
      else begin
        ms = sq.pop_front();
        chk("step_imm26", 64'(Imm26), 64'({3'b0, ms.hw, ms.imm, 5'b0}));
        chk("step_ctrl", 64'(ExtCtrl), 64'(3'b100));
        chk("step_keep", 64'(StepKeep), 64'(ms.keep));
      end
    end
    if (Done) begin
      last_done_t = $time;
      if (dq.size() == 0) chk("unexpected_done", Result, 64'hX);
      else begin
        md = dq.pop_front();
        chk("result", Result, md.res);
        chk("stepcount", 64'(StepCount), 64'(md.cnt));
        if (acc_t.size() != 0)
          chk("latency", 64'(($time - acc_t.pop_front()) / 10), 64'(md.lat));
`ifdef IMM_WIDE_LOAD_SEQ_CHECK_EN
        chk("mismatch", 64'(Mismatch), 64'(md.mm));
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ReqReady && n < 50) begin @(negedge Clk); n++; end
    if (n >= 50) chk("ready_timeout", 64'(ReqReady), 64'h1);
  endtask

  task automatic send(input logic [63:0] v);
    @(negedge Clk);
    ReqValid = 1'b1; ReqValue = v;
    wait_ready();
    acc_t.push_back($time);
    @(posedge Clk); #1;
    ReqValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sq.size() != 0 || dq.size() != 0) && n < 100) begin @(negedge Clk); n++; end
    chk("drain", 64'(sq.size() + dq.size()), 64'h0);
    @(negedge Clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(ReqReady), 64'h1);
    chk({tag, "_imm26"}, 64'(Imm26), 64'h0);
    chk({tag, "_ctrl"}, 64'(ExtCtrl), 64'h0);
    chk({tag, "_valid"}, 64'(StepValid), 64'h0);
    chk({tag, "_keep"}, 64'(StepKeep), 64'h0);
    chk({tag, "_result"}, Result, 64'h0);
    chk({tag, "_done"}, 64'(Done), 64'h0);
    chk({tag, "_count"}, 64'(StepCount), 64'h0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk_reset_vals("por");
    Resetl = 1'b1;

    // Async reset in the middle of a 4-step sequence.
    send(64'h1111_2222_3333_4444);
    @(posedge Clk); #2;
    Resetl = 1'b0; #1;
    chk_reset_vals("midrst");
    @(negedge Clk); Resetl = 1'b1;
    @(negedge Clk);
    chk("post_rst_ready", 64'(ReqReady), 64'h1);
    acc_t.delete();
    mon_en = 1'b1;

    exp_step(2'd0, 16'h1234, 1'b0);
    exp_done(64'h1234, 3'd1, 2, 1'b0);
    send(64'h0000_0000_0000_1234);
    drain();

    exp_step(2'd1, 16'hBEEF, 1'b0);
    exp_step(2'd3, 16'hDEAD, 1'b1);
    exp_done(64'hDEAD_0000_BEEF_0000, 3'd2, 3, 1'b0);
    send(64'hDEAD_0000_BEEF_0000);
    drain();

    // Flush on the second step cycle: no Done, Result keeps previous value.
    exp_step(2'd0, 16'h4444, 1'b0);
    exp_step(2'd1, 16'h3333, 1'b1);
    send(64'h1111_2222_3333_4444);
    @(posedge Clk); #1 Flush = 1'b1;
    @(posedge Clk); #1 Flush = 1'b0;
    @(negedge Clk);
    chk("flush_ready", 64'(ReqReady), 64'h1);
    chk("flush_done", 64'(Done), 64'h0);
    chk("flush_result", Result, 64'hDEAD_0000_BEEF_0000);
    chk("flush_steps_seen", 64'(sq.size()), 64'h0);
    acc_t.delete();

    exp_step(2'd0, 16'h0005, 1'b0);
    exp_done(64'h5, 3'd1, 2, 1'b0);
    send(64'h5);
    drain();

    exp_step(2'd0, 16'h0000, 1'b0);
    exp_done(64'h0, 3'd1, 2, 1'b0);
    send(64'h0);
    drain();

    // Flush in IDLE wins over ReqValid.
    @(negedge Clk);
    Flush = 1'b1; ReqValid = 1'b1; ReqValue = 64'h77;
    @(posedge Clk); #1;
    Flush = 1'b0; ReqValid = 1'b0;
    @(negedge Clk);
    chk("idle_flush_ready", 64'(ReqReady), 64'h1);
    chk("idle_flush_valid", 64'(StepValid), 64'h0);

    // Back-to-back with ReqValid held: second accept only right after Done.
    exp_step(2'd3, 16'h0001, 1'b0);
    exp_done(64'h0001_0000_0000_0000, 3'd1, 2, 1'b0);
    exp_step(2'd0, 16'h0001, 1'b0);
    exp_step(2'd1, 16'h7FFF, 1'b1);
    exp_step(2'd2, 16'h8000, 1'b1);
    exp_step(2'd3, 16'hFFFF, 1'b1);
    exp_done(64'hFFFF_8000_7FFF_0001, 3'd4, 5, 1'b0);
    @(negedge Clk);
    ReqValid = 1'b1; ReqValue = 64'h0001_0000_0000_0000;
    wait_ready();
    acc_t.push_back($time);
    @(posedge Clk); #1 ReqValue = 64'hFFFF_8000_7FFF_0001;
    @(negedge Clk);
    wait_ready();
    chk("b2b_gap", 64'($time - last_done_t), 64'd10);
    acc_t.push_back($time);
    @(posedge Clk); #1 ReqValid = 1'b0;
    drain();

`ifdef IMM_WIDE_LOAD_SEQ_CHECK_EN
    force_zero = 1'b1;
    exp_step(2'd1, 16'h0042, 1'b0);
    exp_done(64'h0, 3'd1, 2, 1'b1);
    send(64'h0000_0000_0042_0000);
    drain();
    force_zero = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
